// File: rtl/mips_multicycle_core_if.sv
// Memory bus between the multi-cycle core (master) and the SoC memory (slave).
//   mem_req_o    request, held until a cycle with mem_ready_i=1
//   mem_we_o     1 = store, 0 = read (fetch or load)
//   mem_addr_o   word-aligned byte address
//   mem_wdata_o  store data
//   mem_rdata_i  read data, valid in the cycle mem_ready_i=1
//   mem_ready_i  completes the transfer when mem_req_o is also high
interface mips_multicycle_core_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;
  logic                  mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core: one FSM, one shared ALU, one memory port.
// Ports:
//   clk           core clock, rising edge
//   reset         asynchronous active-low reset
//   bus           memory master port (req/ready handshake, wait states allowed)
//   pc_o          PC register (already PC+4 once the fetch has completed)
//   alu_result_o  last value written back to the register file
//   retire_o      one-cycle pulse per completed instruction
//   halted_o      sticky stop on illegal opcode/funct or misaligned lw/sw
module mips_multicycle_core #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_core_if.master  bus,
  output logic [ADDR_WIDTH-1:0]   pc_o,
  output logic [31:0]             alu_result_o,
  output logic                    retire_o,
  output logic                    halted_o
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22,
                         F_AND = 6'h24, F_OR  = 6'h25, F_NOR = 6'h27;
  // Jump target is built in a vector of at least 28 bits, then truncated.
  localparam int JW = (ADDR_WIDTH > 28) ? ADDR_WIDTH : 28;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d, a_q, a_d, b_q, b_d, res_q, res_d, alu_q, alu_d;
  logic                  retire_q, retire_d;
  logic                  req_en_q;
  logic [31:0]           rf_q [32];

  logic [5:0]            op, funct;
  logic [4:0]            rs, rt, rd, shamt, dest;
  logic [31:0]           imm_s, imm_z, alu_out;
  logic                  legal, mem_req, wb_we;
  logic [ADDR_WIDTH-1:0] br_tgt, j_tgt;
  logic [JW-1:0]         jt;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm_s = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_z = {16'h0, ir_q[15:0]};
  assign dest  = (op == OP_R) ? rd : rt;

  // req_en_q keeps the request low until the first edge after reset release.
  assign mem_req         = req_en_q && (state_q == S_FETCH || state_q == S_MEM);
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = (state_q == S_MEM) && (op == OP_SW);
  assign bus.mem_addr_o  = (state_q == S_MEM) ? ADDR_WIDTH'(res_q) : pc_q;
  assign bus.mem_wdata_o = b_q;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R: case (funct)
        F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_NOR: legal = 1'b1;
        default: legal = 1'b0;
      endcase
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Shared ALU; lw/sw effective address uses the addi path.
  always_comb begin
    alu_out = a_q + imm_s;
    case (op)
      OP_R: case (funct)
        F_SUB:   alu_out = a_q - b_q;
        F_AND:   alu_out = a_q & b_q;
        F_OR:    alu_out = a_q | b_q;
        F_NOR:   alu_out = ~(a_q | b_q);
        F_SLL:   alu_out = b_q << shamt;
        F_SRL:   alu_out = b_q >> shamt;
        default: alu_out = a_q + b_q;
      endcase
      OP_ORI:  alu_out = a_q | imm_z;
      default: alu_out = a_q + imm_s;
    endcase
  end

  // pc_q already holds PC+4 during EXEC, which is the MIPS base for both targets.
  always_comb begin
    jt       = JW'(pc_q);
    jt[27:0] = {ir_q[25:0], 2'b00};
  end
  assign j_tgt  = ADDR_WIDTH'(jt);
  assign br_tgt = pc_q + ADDR_WIDTH'($signed({imm_s[29:0], 2'b00}));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    alu_d    = alu_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH: if (mem_req && bus.mem_ready_i) begin
        ir_d    = bus.mem_rdata_i;
        pc_d    = pc_q + ADDR_WIDTH'(4);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        res_d = alu_out;
        case (op)
          OP_LW, OP_SW: state_d = (alu_out[1:0] != 2'b00) ? S_HALT : S_MEM;
          OP_BEQ, OP_BNE: begin
            if ((a_q == b_q) == (op == OP_BEQ)) pc_d = br_tgt;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OP_J: begin
            pc_d     = j_tgt;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: if (mem_req && bus.mem_ready_i) begin
        if (op == OP_SW) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else begin
          res_d   = bus.mem_rdata_i;
          state_d = S_WB;
        end
      end
      S_WB: begin
        alu_d    = res_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      alu_q    <= '0;
      retire_q <= 1'b0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      alu_q    <= alu_d;
      retire_q <= retire_d;
      req_en_q <= 1'b1;
    end
  end

  // alu_result_o still updates on a $0 destination; only the array write is dropped.
  assign wb_we = (state_q == S_WB) && (dest != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[dest] <= res_q;
    end
  end

  assign pc_o         = pc_q;
  assign alu_result_o = alu_q;
  assign retire_o     = retire_q;
  assign halted_o     = (state_q == S_HALT);
endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc_o;
  logic [31:0]   alu_result_o;
  logic          retire_o, halted_o;

  mips_multicycle_core_if #(.ADDR_WIDTH(AW)) bus ();

  mips_multicycle_core #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pc_o         (pc_o),
    .alu_result_o (alu_result_o),
    .retire_o     (retire_o),
    .halted_o     (halted_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: rmode 0 = always ready, 1 = ready every 3rd cycle, 2 = never ready.
  logic [31:0] mem [1024];
  int          rmode = 0;
  assign bus.mem_ready_i = (rmode == 0) || (rmode == 1 && (cyc % 3) == 2);
  assign bus.mem_rdata_i = mem[bus.mem_addr_o[11:2]];

  typedef struct { logic [31:0] pc; logic [31:0] res; } exp_t;
  exp_t        sb[$];
  int unsigned rcyc[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] cur_pc, prev_addr, waddr, wdat;
  bit          pend, prev_wait;
  int          xfer, wcnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One cycle of bus service and retire scoreboarding, sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (retire_o) begin
      pend = 1'b1;
      rcyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_result", alu_result_o, e.res);
        chk("retire_pc", cur_pc, e.pc);
      end
    end
    if (prev_wait) begin
      chk("req_hold", bus.mem_req_o, 1);
      chk("addr_hold", bus.mem_addr_o, prev_addr);
    end
    if (bus.mem_req_o && bus.mem_ready_i) begin
      xfer++;
      if (bus.mem_we_o) begin
        mem[bus.mem_addr_o[11:2]] = bus.mem_wdata_o;
        wcnt++;
        waddr = bus.mem_addr_o;
        wdat  = bus.mem_wdata_o;
      end else if (pend) begin
        cur_pc = bus.mem_addr_o;
        pend   = 1'b0;
      end
    end
    prev_wait = bus.mem_req_o && !bus.mem_ready_i;
    prev_addr = bus.mem_addr_o;
  endtask

  task automatic clear_mon();
    sb.delete();
    rcyc.delete();
    pend = 1'b1; prev_wait = 1'b0;
    xfer = 0; wcnt = 0; waddr = '0; wdat = '0; cur_pc = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_mon();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (rcyc.size() < n && !halted_o && k < budget) begin
      tick();
      k++;
    end
    chk("retire_count", rcyc.size(), n);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted_o && k < budget) begin
      tick();
      k++;
    end
    chk("halted", halted_o, 1);
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'h0;
  endtask

  task automatic ex(input logic [31:0] pc, input logic [31:0] res);
    exp_t e;
    e.pc = pc; e.res = res;
    sb.push_back(e);
  endtask

  task automatic load_main();
    clear_mem();
    mem[0]  = 32'h20010005;  // addi $1,$0,5
    mem[1]  = 32'h2002FFFD;  // addi $2,$0,-3
    mem[2]  = 32'h00221820;  // add  $3,$1,$2
    mem[3]  = 32'hAC030008;  // sw   $3,8($0)  overwrites the add, already executed
    mem[4]  = 32'h8C040008;  // lw   $4,8($0)
    mem[5]  = 32'h00013100;  // sll  $6,$1,4
    mem[6]  = 32'h00063882;  // srl  $7,$6,2
    mem[7]  = 32'h00224022;  // sub  $8,$1,$2
    mem[8]  = 32'h00224824;  // and  $9,$1,$2
    mem[9]  = 32'h00225027;  // nor  $10,$1,$2
    mem[10] = 32'h342B8000;  // ori  $11,$1,0x8000
    mem[11] = 32'h20000007;  // addi $0,$0,7
    mem[12] = 32'h00006020;  // add  $12,$0,$0
    mem[13] = 32'h14000004;  // bne  $0,$0,+4  (not taken)
    mem[14] = 32'h08000040;  // j    0x40 -> 0x100
    mem[64] = 32'h1000FFFF;  // beq  $0,$0,-1 (self loop)
  endtask

  // Expected write-back values; -3 sign-extends to FFFFFFFD.
  task automatic push_main();
    ex(32'h00, 32'h5);        ex(32'h04, 32'hFFFFFFFD); ex(32'h08, 32'h2);
    ex(32'h0C, 32'h2);        ex(32'h10, 32'h2);        ex(32'h14, 32'h50);
    ex(32'h18, 32'h14);       ex(32'h1C, 32'h8);        ex(32'h20, 32'h5);
    ex(32'h24, 32'h2);        ex(32'h28, 32'h8005);     ex(32'h2C, 32'h7);
    ex(32'h30, 32'h0);        ex(32'h34, 32'h0);        ex(32'h38, 32'h0);
    ex(32'h100, 32'h0);       ex(32'h100, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    rmode = 0;
    clear_mem();
    do_reset();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_retire", retire_o, 0);
    chk("rst_alu", alu_result_o, 0);

    // Main program, zero-wait memory
    load_main();
    do_reset();
    push_main();
    run_until(17, 400);
    if (rcyc.size() >= 17) begin
      chk("lat_alu", rcyc[1] - rcyc[0], 4);
      chk("lat_sw", rcyc[3] - rcyc[2], 4);
      chk("lat_lw", rcyc[4] - rcyc[3], 5);
      chk("lat_bne", rcyc[13] - rcyc[12], 3);
      chk("lat_j", rcyc[14] - rcyc[13], 3);
      chk("lat_beq", rcyc[15] - rcyc[14], 3);
    end
    chk("sw_count", wcnt, 1);
    chk("sw_addr", waddr, 32'h8);
    chk("sw_data", wdat, 32'h2);
    chk("loop_pc", pc_o, 32'h100);

    // Same program, ready every third cycle
    load_main();
    rmode = 1;
    do_reset();
    push_main();
    run_until(17, 2000);
    chk("ws_sw_count", wcnt, 1);
    chk("ws_sw_addr", waddr, 32'h8);
    chk("ws_sw_data", wdat, 32'h2);

    // Misaligned lw: halts after the fetch with no data access
    clear_mem();
    mem[0] = 32'h8C050002;   // lw $5,2($0)
    rmode = 0;
    do_reset();
    wait_halt(50);
    chk("mis_pc", pc_o, 32'h4);
    chk("mis_req", bus.mem_req_o, 0);
    chk("mis_xfers", xfer, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("mis_sticky", halted_o, 1);
    chk("mis_xfers_after", xfer, 1);
    chk("mis_retires", rcyc.size(), 0);

    // Illegal opcode
    clear_mem();
    mem[0] = 32'hFC000000;
    do_reset();
    wait_halt(50);
    chk("ill_pc", pc_o, 32'h4);
    chk("ill_retires", rcyc.size(), 0);

    // Async reset pulse while a fetch is stalled
    clear_mem();
    mem[0] = 32'h20010005;   // addi $1,$0,5
    mem[1] = 32'h1000FFFF;   // beq $0,$0,-1
    rmode = 2;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("stall_req", bus.mem_req_o, 1);
    chk("stall_addr", bus.mem_addr_o, 32'h0);
    #2;
    reset = 1'b0;
    clear_mon();
    #1;
    chk("async_req_low", bus.mem_req_o, 0);
    chk("async_halted", halted_o, 0);
    tick();
    reset = 1'b1;
    rmode = 0;
    chk("rel_pc", pc_o, 32'h0);
    chk("rel_req_first", bus.mem_req_o, 0);
    ex(32'h0, 32'h5);
    tick();
    chk("rel_req_next", bus.mem_req_o, 1);
    run_until(1, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
